// File: rtl/spram_pkg.sv
// Shared types and sizing for the SPRAM Wishbone bridge.
// The clear-sweep state exists only when SPRAM_CLEAR_EN is defined.
package spram_pkg;
    localparam int SPRAM_WORDS = 32768;
    localparam int SPRAM_AW    = 15;
    localparam int RAM_ADDR_W  = 22;
    localparam int NUM_LANES   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RDATA = 3'd3,
`ifdef SPRAM_CLEAR_EN
        ST_CLEAR = 3'd5,
`endif
        ST_ACK   = 3'd4
    } state_t;
endpackage

// File: rtl/spram_clear_seq.sv
// Word-address up-counter for the post-reset zero-fill sweep (SPRAM_CLEAR_EN builds).
// done rises once the last word address has been handed out.
module spram_clear_seq #(
    parameter int WORDS = 32768,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] addr,
    output logic          done
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            done <= 1'b0;
        end else if (start && !done) begin
            addr <= addr + 1'b1;
            done <= (addr == AW'(WORDS - 1));
        end
    end
endmodule

// File: rtl/spram_wb_bridge.sv
// Wishbone classic slave driving the iCE40UP5K SPRAM port; one ack per accepted cycle.
// Define SPRAM_CLEAR_EN to zero-fill the bank after every reset before accepting requests.
module spram_wb_bridge
    import spram_pkg::*;
#(
    parameter int WORDS = SPRAM_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    input  logic                  wb_we,
    input  logic [NUM_LANES-1:0]  wb_sel,
    input  logic [31:0]           wb_adr,
    input  logic [31:0]           wb_dat,
    output logic [31:0]           wb_rdt,
    output logic                  wb_ack,
    output logic [NUM_LANES-1:0]  ram_wen,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    output logic                  busy
);
    localparam int AW = $clog2(WORDS);

    state_t                  state, state_d;
    logic                    ack_q, ack_d;
    logic [31:0]             rdt_d, wdata_d;
    logic [NUM_LANES-1:0]    wen_d;
    logic [RAM_ADDR_W-1:0]   addr_d;
    logic                    req;
    logic [AW-1:0]           index;
    logic                    unused_adr;

    assign req        = wb_cyc & wb_stb;
    assign index      = wb_adr[AW+1:2];
    assign unused_adr = ^{wb_adr[31:AW+2], wb_adr[1:0]};

    // A master that abandons its cycle never sees the late ack.
    assign wb_ack = ack_q & wb_cyc;

`ifdef SPRAM_CLEAR_EN
    localparam state_t RST_STATE = ST_CLEAR;
    logic [AW-1:0] clr_addr;
    logic          clr_done;

    spram_clear_seq #(.WORDS(WORDS), .AW(AW)) u_clear (
        .clk   (clk),
        .rst   (rst),
        .start (state == ST_CLEAR),
        .addr  (clr_addr),
        .done  (clr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= 1'b1;
        else     busy <= (state_d == ST_CLEAR);
    end
`else
    localparam state_t RST_STATE = ST_IDLE;
    assign busy = 1'b0;
`endif

    always_comb begin
        state_d = state;
        ack_d   = ack_q;
        rdt_d   = wb_rdt;
        wen_d   = ram_wen;
        addr_d  = ram_addr;
        wdata_d = ram_wdata;
        case (state)
            ST_IDLE: begin
                wen_d = '0;
                if (req) begin
                    addr_d  = RAM_ADDR_W'(index);
                    wdata_d = wb_dat;
                    wen_d   = wb_we ? wb_sel : '0;
                    state_d = wb_we ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                wen_d   = '0;
                ack_d   = 1'b1;
                state_d = ST_ACK;
            end
            ST_READ:  state_d = ST_RDATA;
            ST_RDATA: begin
                rdt_d   = ram_rdata;
                ack_d   = 1'b1;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                ack_d   = 1'b0;
                state_d = ST_IDLE;
            end
`ifdef SPRAM_CLEAR_EN
            ST_CLEAR: begin
                if (clr_done) begin
                    wen_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    wen_d   = '1;
                    wdata_d = '0;
                    addr_d  = RAM_ADDR_W'(clr_addr);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RST_STATE;
            ack_q     <= 1'b0;
            wb_rdt    <= '0;
            ram_wen   <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state     <= state_d;
            ack_q     <= ack_d;
            wb_rdt    <= rdt_d;
            ram_wen   <= wen_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
        end
    end
endmodule

// File: tb/tb_spram_wb_bridge.sv
// Bench for spram_wb_bridge with a 1-cycle-latency behavioural SPRAM and a read-data scoreboard.
// Builds with or without SPRAM_CLEAR_EN.
module tb_spram_wb_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [3:0]  wb_sel = '0;
    logic [31:0] wb_adr = '0, wb_dat = '0;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic [3:0]  ram_wen;
    logic [21:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        busy;
    logic        preload = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

`ifdef SPRAM_CLEAR_EN
    localparam int  BOUND     = 40000;
    localparam logic RST_BUSY = 1'b1;
    localparam logic [31:0] AFTER_RST = 32'h0;
`else
    localparam int  BOUND     = 50;
    localparam logic RST_BUSY = 1'b0;
    localparam logic [31:0] AFTER_RST = 32'hDEADBEEF;
`endif

    always #5 clk = ~clk;

    spram_wb_bridge dut (
        .clk(clk), .rst(rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_dat(wb_dat), .wb_rdt(wb_rdt),
        .wb_ack(wb_ack), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    // Behavioural SPRAM: byte-lane writes, registered read data.
    logic [31:0] mem [0:32767];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32768; i++) mem[i] <= 32'hFFFF_FFFF;
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) mem[ram_addr[14:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        ram_rdata <= mem[ram_addr[14:0]];
    end

    // One bus cycle; lat counts edges from the accepting edge to ack (-1 on timeout).
    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdt, output int lat,
                       output logic [3:0] wen1, output logic [21:0] addr1,
                       output logic [3:0] wen_ack);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
        lat = 0; wen1 = '0; addr1 = '0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin wen1 = ram_wen; addr1 = ram_addr; end
        end while (!wb_ack && lat < BOUND);
        rdt = wb_rdt;
        wen_ack = ram_wen;
        if (!wb_ack) lat = -1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (busy && n < BOUND) begin @(posedge clk); #1; n++; end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL wait_ready: busy=%b want 0", busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1; preload = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        tests++; if (wb_ack !== 1'b0)    begin fails++; $display("FAIL rst_ack: %b want 0", wb_ack); end
        tests++; if (wb_rdt !== 32'h0)   begin fails++; $display("FAIL rst_rdt: %h want 0", wb_rdt); end
        tests++; if (ram_wen !== 4'h0)   begin fails++; $display("FAIL rst_wen: %h want 0", ram_wen); end
        tests++; if (ram_addr !== 22'h0) begin fails++; $display("FAIL rst_addr: %h want 0", ram_addr); end
        tests++; if (ram_wdata !== 32'h0) begin fails++; $display("FAIL rst_wdata: %h want 0", ram_wdata); end
        tests++; if (busy !== RST_BUSY)  begin fails++; $display("FAIL rst_busy: %b want %b", busy, RST_BUSY); end
        rst = 1'b0;
    endtask

`ifdef SPRAM_CLEAR_EN
    task automatic test_clear();
        logic [31:0] rdt; int lat; logic [3:0] w1, wa; logic [21:0] a1;
        int nbusy = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (busy) nbusy++;
            if (i == 0) begin
                tests++; if (ram_wen !== 4'hF) begin fails++; $display("FAIL clr_wen: %h want F", ram_wen); end
                tests++; if (ram_addr !== 22'd0) begin fails++; $display("FAIL clr_addr0: %0d want 0", ram_addr); end
                tests++; if (ram_wdata !== 32'h0) begin fails++; $display("FAIL clr_wdata: %h want 0", ram_wdata); end
            end
            if (i == 1) begin
                tests++; if (ram_addr !== 22'd1) begin fails++; $display("FAIL clr_addr1: %0d want 1", ram_addr); end
            end
        end
        tests++; if (nbusy != 5) begin fails++; $display("FAIL clr_busy_early: %0d want 5", nbusy); end
        // Request raised during the sweep: held until the full 32768-word fill ends.
        exp_q.push_back(32'h0);
        bus(1'b0, 32'h0, 32'h0, 4'h0, rdt, lat, w1, a1, wa);
        tests++; if (lat != 32767) begin fails++; $display("FAIL clr_hold_lat: %0d want 32767", lat); end
        tests++; if (rdt !== exp_q.pop_front()) begin fails++; $display("FAIL clr_rd0: %h want 0", rdt); end
        exp_q.push_back(32'h0);
        bus(1'b0, 32'h0000_FFFC, 32'h0, 4'h0, rdt, lat, w1, a1, wa);
        tests++; if (rdt !== exp_q.pop_front()) begin fails++; $display("FAIL clr_rd16383: %h want 0", rdt); end
        exp_q.push_back(32'h0);
        bus(1'b0, 32'h0001_FFFC, 32'h0, 4'h0, rdt, lat, w1, a1, wa);
        tests++; if (rdt !== exp_q.pop_front()) begin fails++; $display("FAIL clr_rd32767: %h want 0", rdt); end
    endtask
`else
    task automatic test_idle_after_reset();
        @(posedge clk); #1;
        tests++; if (ram_wen !== 4'h0) begin fails++; $display("FAIL idle_wen: %h want 0", ram_wen); end
    endtask
`endif

    task automatic test_write_read();
        logic [31:0] rdt; int lat; logic [3:0] w1, wa; logic [21:0] a1;
        bus(1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, rdt, lat, w1, a1, wa);
        tests++; if (lat != 2)   begin fails++; $display("FAIL wr_lat: %0d want 2", lat); end
        tests++; if (w1 !== 4'hF) begin fails++; $display("FAIL wr_wen: %h want F", w1); end
        tests++; if (a1 !== 22'd4) begin fails++; $display("FAIL wr_addr: %0d want 4", a1); end
        tests++; if (wa !== 4'h0) begin fails++; $display("FAIL wr_wen_drop: %h want 0", wa); end
        exp_q.push_back(32'hDEADBEEF);
        bus(1'b0, 32'h0000_0010, 32'h0, 4'h0, rdt, lat, w1, a1, wa);
        tests++; if (lat != 3)   begin fails++; $display("FAIL rd_lat: %0d want 3", lat); end
        tests++; if (w1 !== 4'h0) begin fails++; $display("FAIL rd_wen: %h want 0", w1); end
        tests++; if (rdt !== exp_q.pop_front()) begin fails++; $display("FAIL rd_data: %h want DEADBEEF", rdt); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rdt; int lat; logic [3:0] w1, wa; logic [21:0] a1;
        bus(1'b1, 32'h20, 32'h11223344, 4'hF, rdt, lat, w1, a1, wa);
        bus(1'b1, 32'h20, 32'h00AA0000, 4'b0100, rdt, lat, w1, a1, wa);
        tests++; if (w1 !== 4'b0100) begin fails++; $display("FAIL lane_wen: %b want 0100", w1); end
        exp_q.push_back(32'h11AA3344);
        bus(1'b0, 32'h20, 32'h0, 4'h0, rdt, lat, w1, a1, wa);
        tests++; if (rdt !== exp_q.pop_front()) begin fails++; $display("FAIL lane_data: %h want 11AA3344", rdt); end
    endtask

    task automatic test_sel_zero();
        logic [31:0] rdt; int lat; logic [3:0] w1, wa; logic [21:0] a1;
        bus(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rdt, lat, w1, a1, wa);
        tests++; if (lat != 2)    begin fails++; $display("FAIL sel0_lat: %0d want 2", lat); end
        tests++; if (w1 !== 4'h0) begin fails++; $display("FAIL sel0_wen: %h want 0", w1); end
        exp_q.push_back(32'h11AA3344);
        bus(1'b0, 32'h20, 32'h0, 4'h0, rdt, lat, w1, a1, wa);
        tests++; if (rdt !== exp_q.pop_front()) begin fails++; $display("FAIL sel0_data: %h want 11AA3344", rdt); end
    endtask

    task automatic test_alias();
        logic [31:0] rdt; int lat; logic [3:0] w1, wa; logic [21:0] a1;
        bus(1'b1, 32'h0002_0004, 32'hCAFEF00D, 4'hF, rdt, lat, w1, a1, wa);
        tests++; if (a1 !== 22'd1) begin fails++; $display("FAIL alias_addr: %0d want 1", a1); end
        exp_q.push_back(32'hCAFEF00D);
        bus(1'b0, 32'h0000_0004, 32'h0, 4'h0, rdt, lat, w1, a1, wa);
        tests++; if (rdt !== exp_q.pop_front()) begin fails++; $display("FAIL alias_data: %h want CAFEF00D", rdt); end
    endtask

    task automatic test_cyc_drop();
        logic [31:0] rdt; int lat; logic [3:0] w1, wa; logic [21:0] a1;
        int nack = 0;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h30; wb_dat = 32'hA5A5A5A5; wb_sel = 4'hF;
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        tests++; if (ram_wen !== 4'hF) begin fails++; $display("FAIL drop_wen: %h want F", ram_wen); end
        repeat (4) begin @(posedge clk); #1; if (wb_ack) nack++; end
        tests++; if (nack != 0) begin fails++; $display("FAIL drop_ack: %0d acks want 0", nack); end
        exp_q.push_back(32'hA5A5A5A5);
        bus(1'b0, 32'h30, 32'h0, 4'h0, rdt, lat, w1, a1, wa);
        tests++; if (rdt !== exp_q.pop_front()) begin fails++; $display("FAIL drop_data: %h want A5A5A5A5", rdt); end
    endtask

    task automatic test_back_to_back();
        int nack, adj, bad;
        logic prev;
        logic [31:0] e;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h40; wb_dat = 32'h01020304; wb_sel = 4'hF;
        nack = 0; adj = 0; bad = 0; prev = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (wb_ack) begin
                nack++;
                if (prev) adj++;
                if ((c - 2) % 3 != 0) bad++;
            end
            prev = wb_ack;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        repeat (3) @(posedge clk);
        tests++; if (nack != 4) begin fails++; $display("FAIL b2b_wr_acks: %0d want 4", nack); end
        tests++; if (adj != 0 || bad != 0) begin fails++; $display("FAIL b2b_wr_spacing: adj=%0d off=%0d want 0/0", adj, bad); end

        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h10;
        repeat (3) exp_q.push_back(32'hDEADBEEF);
        nack = 0; adj = 0; bad = 0; prev = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (wb_ack) begin
                nack++;
                if (prev) adj++;
                if ((c - 3) % 4 != 0) bad++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
                tests++;
                if (wb_rdt !== e) begin fails++; $display("FAIL b2b_rd_data: %h want %h", wb_rdt, e); end
            end
            prev = wb_ack;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (3) @(posedge clk);
        tests++; if (nack != 3) begin fails++; $display("FAIL b2b_rd_acks: %0d want 3", nack); end
        tests++; if (adj != 0 || bad != 0) begin fails++; $display("FAIL b2b_rd_spacing: adj=%0d off=%0d want 0/0", adj, bad); end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_rd_left: %0d unread want 0", exp_q.size()); end
        exp_q.delete();
    endtask

`ifndef SPRAM_CLEAR_EN
    task automatic test_rst_write();
        logic [31:0] rdt; int lat; logic [3:0] w1, wa; logic [21:0] a1;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h10; wb_dat = 32'h12345678; wb_sel = 4'hF;
        @(posedge clk); #1;
        tests++; if (ram_wen !== 4'hF) begin fails++; $display("FAIL rstw_pre_wen: %h want F", ram_wen); end
        rst = 1'b1; #1;
        tests++; if (ram_wen !== 4'h0) begin fails++; $display("FAIL rstw_wen: %h want 0", ram_wen); end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk); rst = 1'b0;
        // The write edge never came, so the old word survives.
        exp_q.push_back(32'hDEADBEEF);
        bus(1'b0, 32'h10, 32'h0, 4'h0, rdt, lat, w1, a1, wa);
        tests++; if (rdt !== exp_q.pop_front()) begin fails++; $display("FAIL rstw_data: %h want DEADBEEF", rdt); end
    endtask
`endif

    task automatic test_rst_read();
        logic [31:0] rdt; int lat; logic [3:0] w1, wa; logic [21:0] a1;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h10;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        tests++; if (wb_ack !== 1'b0)   begin fails++; $display("FAIL rstr_ack: %b want 0", wb_ack); end
        tests++; if (ram_wen !== 4'h0)  begin fails++; $display("FAIL rstr_wen: %h want 0", ram_wen); end
        tests++; if (ram_addr !== 22'h0) begin fails++; $display("FAIL rstr_addr: %h want 0", ram_addr); end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk); rst = 1'b0;
        wait_ready();
        exp_q.push_back(AFTER_RST);
        bus(1'b0, 32'h10, 32'h0, 4'h0, rdt, lat, w1, a1, wa);
        tests++; if (lat != 3) begin fails++; $display("FAIL rstr_lat: %0d want 3", lat); end
        tests++; if (rdt !== exp_q.pop_front()) begin fails++; $display("FAIL rstr_data: %h want %h", rdt, AFTER_RST); end
    endtask

    initial begin
        test_reset();
`ifdef SPRAM_CLEAR_EN
        test_clear();
`else
        test_idle_after_reset();
`endif
        test_write_read();
        test_byte_lanes();
        test_sel_zero();
        test_alias();
        test_cyc_drop();
        test_back_to_back();
`ifndef SPRAM_CLEAR_EN
        test_rst_write();
`endif
        test_rst_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
